// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   A single WIDTH-bit shared register written by NREQ requesters under
//   round-robin arbitration. One operation (load / set all ones / clear / nop)
//   is applied per clock. All outputs are registered.
//
//   Optional feature macro: REGARB_LOCK_EN
//     When defined, a winner that also asserts lock keeps the register for
//     back-to-back cycles (state LOCKED) until it drops req or lock.
//     When undefined, lock is ignored and every grant is a single cycle.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   req        in   [NREQ-1:0] per-requester request
//   op         in   [2*NREQ-1:0] op[2i+1:2i]: 00 load, 01 set, 10 clear, 11 nop
//   din        in   [WIDTH*NREQ-1:0] din[WIDTH*i +: WIDTH] load data
//   lock       in   [NREQ-1:0] per-requester lock request
//   gnt        out  [NREQ-1:0] registered one-hot grant, zero when idle
//   ack        out  registered pulse: an operation was applied at the last edge
//   owner      out  [IDXW-1:0] index of the last granted requester
//   q          out  [WIDTH-1:0] shared register contents
//   state_dbg  out  current FSM state (0 = IDLE, 1 = LOCKED)
//
// Handshake: a requester holds req (with op/din stable) until it sees
// gnt[i]=1 in the cycle after the edge that applied its operation; a
// requester that keeps req high is simply re-arbitrated at the next edge.
module reg_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   din,
  input  logic [NREQ-1:0]         lock,
  output logic [NREQ-1:0]         gnt,
  output logic                    ack,
  output logic [IDXW-1:0]         owner,
  output logic [WIDTH-1:0]        q,
  output logic                    state_dbg
);

`ifdef REGARB_LOCK_EN
  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0} state_t;
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              ack_q, ack_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]  q_q, q_d;

  // Combinational helpers
  logic              found;
  logic [IDXW-1:0]   win;
  logic [IDXW-1:0]   idx;
  logic [NREQ-1:0]   req_sh;
  logic              apply;
  logic [IDXW-1:0]   sel;
  logic [2*NREQ-1:0] op_sh;
  logic [WIDTH*NREQ-1:0] din_sh;

  function automatic logic [IDXW-1:0] inc_wrap(input logic [IDXW-1:0] x);
    return (x == IDXW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    ack_d   = 1'b0;
    owner_d = owner_q;
    q_d     = q_q;
    found   = 1'b0;
    win     = '0;
    idx     = ptr_q;
    req_sh  = '0;
    apply   = 1'b0;
    sel     = '0;
    op_sh   = '0;
    din_sh  = '0;

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    for (int k = 0; k < NREQ; k++) begin
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = inc_wrap(idx);
    end

`ifdef REGARB_LOCK_EN
    if (state_q == S_LOCKED) begin
      // Only the lock owner is looked at; others keep waiting.
      sel    = owner_q;
      req_sh = req >> owner_q;
      if (!req_sh[0]) begin
        state_d = S_IDLE;
        ptr_d   = inc_wrap(owner_q);
      end else begin
        apply  = 1'b1;
        req_sh = lock >> owner_q;
        if (!req_sh[0]) begin
          // Lock released: this cycle's op still lands, then rotate on.
          state_d = S_IDLE;
          ptr_d   = inc_wrap(owner_q);
        end
      end
    end else
`endif
    if (found) begin
      apply   = 1'b1;
      sel     = win;
      owner_d = win;
      ptr_d   = inc_wrap(win);
`ifdef REGARB_LOCK_EN
      req_sh = lock >> win;
      if (req_sh[0]) begin
        // Pointer stays put while locked; it is set on exit.
        state_d = S_LOCKED;
        ptr_d   = ptr_q;
      end
`endif
    end

    if (apply) begin
      gnt_d  = NREQ'(1) << sel;
      ack_d  = 1'b1;
      op_sh  = op >> {sel, 1'b0};
      din_sh = din >> (WIDTH * int'(sel));
      case (op_sh[1:0])
        2'b00:   q_d = din_sh[WIDTH-1:0];
        2'b01:   q_d = '1;
        2'b10:   q_d = '0;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      owner_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      q_q     <= q_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign owner     = owner_q;
  assign q         = q_q;
  assign state_dbg = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (NREQ=4, WIDTH=8, IDXW=3).
// Table of directed vectors followed by hand-written lock / reset sequences.
module tb_reg_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] din;
  logic [3:0]  lock;
  logic [3:0]  gnt;
  logic        ack;
  logic [2:0]  owner;
  logic [7:0]  q;
  logic        state_dbg;

  int n_cmp;
  int n_bad;

  reg_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .din       (din),
    .lock      (lock),
    .gnt       (gnt),
    .ack       (ack),
    .owner     (owner),
    .q         (q),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] din;
    logic [3:0]  lock;
    logic [3:0]  e_gnt;
    logic        e_ack;
    logic [2:0]  e_owner;
    logic [7:0]  e_q;
  } vec_t;

  vec_t vecs[15];

  // Driver: set inputs, take one rising edge, settle away from the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [7:0] o,
                      input logic [31:0] d, input logic [3:0] lk);
    rst  = r;
    req  = rq;
    op   = o;
    din  = d;
    lock = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic e_ack,
                         input logic [2:0] e_owner, input logic [7:0] e_q);
    chk({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
    chk({tag, ".ack"},   32'(ack),   32'(e_ack));
    chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
    chk({tag, ".q"},     32'(q),     32'(e_q));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; req = '0; op = '0; din = '0; lock = '0;

    //            rst   req      op     din           lock     gnt      ack   own   q
    vecs[0]  = '{1'b0, 4'b1111, 8'h00, 32'h44332211, 4'b0000, 4'b0000, 1'b0, 3'd0, 8'h00};
    vecs[1]  = '{1'b0, 4'b1111, 8'h00, 32'h44332211, 4'b0000, 4'b0000, 1'b0, 3'd0, 8'h00};
    vecs[2]  = '{1'b1, 4'b1111, 8'h00, 32'h44332211, 4'b0000, 4'b0001, 1'b1, 3'd0, 8'h11};
    vecs[3]  = '{1'b1, 4'b1111, 8'h00, 32'h44332211, 4'b0000, 4'b0010, 1'b1, 3'd1, 8'h22};
    vecs[4]  = '{1'b1, 4'b1111, 8'h00, 32'h44332211, 4'b0000, 4'b0100, 1'b1, 3'd2, 8'h33};
    vecs[5]  = '{1'b1, 4'b1111, 8'h00, 32'h44332211, 4'b0000, 4'b1000, 1'b1, 3'd3, 8'h44};
    vecs[6]  = '{1'b1, 4'b1111, 8'h00, 32'h44332211, 4'b0000, 4'b0001, 1'b1, 3'd0, 8'h11};
    vecs[7]  = '{1'b1, 4'b0000, 8'h00, 32'h44332211, 4'b0000, 4'b0000, 1'b0, 3'd0, 8'h11};
    vecs[8]  = '{1'b1, 4'b0100, 8'h10, 32'h44332211, 4'b0000, 4'b0100, 1'b1, 3'd2, 8'hFF};
    vecs[9]  = '{1'b1, 4'b0100, 8'h20, 32'h44332211, 4'b0000, 4'b0100, 1'b1, 3'd2, 8'h00};
    vecs[10] = '{1'b1, 4'b0100, 8'h30, 32'h44332211, 4'b0000, 4'b0100, 1'b1, 3'd2, 8'h00};
    vecs[11] = '{1'b1, 4'b1000, 8'h00, 32'hA5332211, 4'b0000, 4'b1000, 1'b1, 3'd3, 8'hA5};
    vecs[12] = '{1'b1, 4'b1001, 8'h00, 32'hA5332211, 4'b0000, 4'b0001, 1'b1, 3'd0, 8'h11};
    vecs[13] = '{1'b1, 4'b1001, 8'h00, 32'hA5332211, 4'b0000, 4'b1000, 1'b1, 3'd3, 8'hA5};
    vecs[14] = '{1'b1, 4'b0000, 8'h00, 32'hA5332211, 4'b0000, 4'b0000, 1'b0, 3'd3, 8'hA5};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].op, vecs[i].din, vecs[i].lock);
      chk_all($sformatf("v%0d", i), vecs[i].e_gnt, vecs[i].e_ack, vecs[i].e_owner, vecs[i].e_q);
    end
    // ptr is now 0, q=A5, owner=3.

`ifdef REGARB_LOCK_EN
    step(1'b0, 4'b0000, 8'h00, 32'h00005A11, 4'b0000);
    chk_all("l_rst", 4'b0000, 1'b0, 3'd0, 8'h00);
    step(1'b1, 4'b0001, 8'h00, 32'h00005A11, 4'b0000);
    chk_all("l_r0", 4'b0001, 1'b1, 3'd0, 8'h11);
    // Requester 1 locks and loads 5A,5B,5C while requester 0 waits.
    step(1'b1, 4'b0011, 8'h00, 32'h00005A11, 4'b0010);
    chk_all("l_a", 4'b0010, 1'b1, 3'd1, 8'h5A);
    chk("l_a.state", 32'(state_dbg), 32'd1);
    step(1'b1, 4'b0011, 8'h00, 32'h00005B11, 4'b0010);
    chk_all("l_b", 4'b0010, 1'b1, 3'd1, 8'h5B);
    chk("l_b.state", 32'(state_dbg), 32'd1);
    step(1'b1, 4'b0011, 8'h00, 32'h00005C11, 4'b0000);
    chk_all("l_c", 4'b0010, 1'b1, 3'd1, 8'h5C);
    chk("l_c.state", 32'(state_dbg), 32'd0);
    step(1'b1, 4'b0011, 8'h00, 32'h00005C11, 4'b0000);
    chk_all("l_next", 4'b0001, 1'b1, 3'd0, 8'h11);
    // Exit by owner dropping req: no op applied, ptr moves past owner.
    step(1'b1, 4'b0010, 8'h00, 32'h00007711, 4'b0010);
    chk_all("d_lock", 4'b0010, 1'b1, 3'd1, 8'h77);
    chk("d_lock.state", 32'(state_dbg), 32'd1);
    step(1'b1, 4'b0001, 8'h00, 32'h00007711, 4'b0010);
    chk_all("d_drop", 4'b0000, 1'b0, 3'd1, 8'h77);
    chk("d_drop.state", 32'(state_dbg), 32'd0);
    step(1'b1, 4'b0011, 8'h00, 32'h00007711, 4'b0000);
    chk_all("d_next", 4'b0001, 1'b1, 3'd0, 8'h11);
    // Reset while locked.
    step(1'b1, 4'b0010, 8'h00, 32'h00009911, 4'b0010);
    chk_all("r_lock", 4'b0010, 1'b1, 3'd1, 8'h99);
    chk("r_lock.state", 32'(state_dbg), 32'd1);
    step(1'b0, 4'b1111, 8'h00, 32'h44332211, 4'b1111);
    chk_all("r_rst", 4'b0000, 1'b0, 3'd0, 8'h00);
    chk("r_rst.state", 32'(state_dbg), 32'd0);
    step(1'b1, 4'b1111, 8'h00, 32'h44332211, 4'b0000);
    chk_all("r_first", 4'b0001, 1'b1, 3'd0, 8'h11);
`else
    // Lock inputs have no effect: plain rotation continues.
    step(1'b1, 4'b0011, 8'h00, 32'h44332211, 4'b0011);
    chk_all("n_a", 4'b0001, 1'b1, 3'd0, 8'h11);
    step(1'b1, 4'b0011, 8'h00, 32'h44332211, 4'b0011);
    chk_all("n_b", 4'b0010, 1'b1, 3'd1, 8'h22);
    chk("n_b.state", 32'(state_dbg), 32'd0);
    step(1'b1, 4'b0011, 8'h00, 32'h44332211, 4'b0011);
    chk_all("n_c", 4'b0001, 1'b1, 3'd0, 8'h11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Arbitrates a single shared WIDTH-bit register between NREQ requesters.
- The register is a bank of positive-edge flops with synchronous clear, set and load.
- Each requester asks for one operation: load data, set all ones, clear, or no-op.
- Arbitration is round-robin; one operation is applied per clock. Optional bus locking gives one requester back-to-back ownership.
- Sits between control agents and a shared status/config register in the datapath.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- WIDTH, 8, width of the shared register.
- IDXW, 3, width of the owner index; must satisfy 2^IDXW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request; bit i belongs to requester i.
- op  in  2*NREQ  per-requester operation; op[2i+1:2i] belongs to requester i. Encoding: 00 load, 01 set, 10 clear, 11 nop.
- din  in  WIDTH*NREQ  per-requester load data; din[WIDTH*i +: WIDTH].
- lock  in  NREQ  per-requester lock request; only used when REGARB_LOCK_EN is defined.
- gnt  out  NREQ  registered one-hot grant; all zero when idle.
- ack  out  1  registered pulse: an operation was applied at the last edge.
- owner  out  IDXW  index of the last granted requester.
- q  out  WIDTH  shared register contents.

Behaviour:
- Reset:
  - When rst=0 at a rising edge: q=0, gnt=0, ack=0, owner=0, rr pointer=0, state=IDLE.
  - Reset has priority over every request, including mid-lock; the lock is dropped.
- Arbitration (state IDLE, evaluated every edge):
  - The winner is the first i with req[i]=1, searching from ptr upward and wrapping modulo NREQ.
  - If req=0 at the edge: gnt<=0, ack<=0; q, owner and ptr hold.
- On a win, all at the same edge (one-cycle latency from sampled req):
  - gnt<=onehot(winner), ack<=1, owner<=winner, ptr<=(winner+1) mod NREQ.
  - q is updated from op[winner]: 00 q<=din[winner]; 01 q<=all ones; 10 q<=0; 11 q holds.
  - A nop still consumes the grant and produces ack.
- Request protocol:
  - gnt[i] is high in the cycle after the edge that applied requester i's operation.
  - A requester holding req high is re-arbitrated normally. Because of pointer rotation it cannot win twice in a row while another requester is requesting.
  - A lone continuous requester wins every cycle.
- Wrap-around: when the pointer is at NREQ-1 and wins, ptr becomes 0.
- Simultaneous events: with all requesters active, grants rotate 0,1,..,NREQ-1,0.
- Outputs are registered only; there is no combinational path from req to gnt.

Optional Feature:
- Macro: REGARB_LOCK_EN.
- Defined:
  - A second state, LOCKED, is added.
  - In IDLE, if the winner also has lock[winner]=1, the next state is LOCKED and owner is latched.
  - In LOCKED, only owner's req/op/din are considered. Each edge with req[owner]=1 applies owner's op, keeps gnt[owner]=1 and pulses ack=1.
  - The pointer is not advanced while locked.
  - Exit to IDLE at the first edge where req[owner]=0 (gnt<=0, ack<=0, ptr<=owner+1), or where lock[owner]=0. A lock=0 exit still applies that cycle's op and then sets ptr<=owner+1.
  - Other requesters wait, and their requests are retained externally.
- Not defined: the lock input is ignored, the LOCKED state does not exist, and every grant is single-cycle round-robin.

Test Plan (NREQ=4, WIDTH=8):
- rst=0 for 2 edges with all req=1 -> q=00, gnt=0000, ack=0, owner=0. First edge after rst=1 -> gnt=0001, q from requester 0.
- req=1111, ops load with din 11,22,33,44, held for 5 edges -> gnt sequence 0001,0010,0100,1000,0001; q sequence 11,22,33,44,11; ack=1 each cycle.
- req=0100 with op=01, then op=10, then op=11 -> q=FF, then 00, then 00 held; ack=1 all three cycles; owner=2.
- req[3]=1 only, load A5, then req=1001 with both requesting -> q=A5, owner=3; next grant goes to requester 0 (ptr wrapped to 0).
- REGARB_LOCK_EN: req=0011, lock[1]=1 (requester 0 already served, ptr=1), requester 1 loads 5A,5B,5C -> gnt=0010 for 3 cycles, q=5A,5B,5C, requester 0 starved. Then lock[1]=0 -> requester 0 is granted next.
- REGARB_LOCK_EN: reset asserted while LOCKED -> state IDLE, gnt=0000, q=00. After reset, requester 0 wins first.
